// File: rtl/dmi_boot_sequencer.sv
// Boot sequencer mastering the debug module's DMI port: halts the hart, hands
// off to a memory loader, points DPC at the boot address and resumes the hart.
module dmi_boot_sequencer #(
  parameter logic [31:0] BootAddr    = 32'h8000_0000,
  parameter logic [9:0]  HartSel     = 10'd0,
  parameter int unsigned PollTimeout = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  output logic        load_req_o,
  input  logic        load_done_i,
  output logic        dmi_req_valid_o,
  input  logic        dmi_req_ready_i,
  output logic [6:0]  dmi_req_addr_o,
  output logic [1:0]  dmi_req_op_o,
  output logic [31:0] dmi_req_data_o,
  input  logic        dmi_resp_valid_i,
  output logic        dmi_resp_ready_o,
  input  logic [31:0] dmi_resp_data_i,
  input  logic [1:0]  dmi_resp_resp_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [2:0]  err_code_o
);

  localparam int unsigned StepW = 4;
  localparam int unsigned PollW = (PollTimeout > 1) ? $clog2(PollTimeout) : 1;
  localparam logic [PollW-1:0] PollLast = PollW'(PollTimeout - 1);

  localparam logic [6:0] AddrData0      = 7'h04;
  localparam logic [6:0] AddrDmcontrol  = 7'h10;
  localparam logic [6:0] AddrDmstatus   = 7'h11;
  localparam logic [6:0] AddrAbstractcs = 7'h16;
  localparam logic [6:0] AddrCommand    = 7'h17;

  localparam logic [1:0] OpRead  = 2'd1;
  localparam logic [1:0] OpWrite = 2'd2;

  localparam logic [31:0] DmActiveHart = {6'd0, HartSel, 15'd0, 1'b1};
  localparam logic [31:0] HaltReq      = 32'h8000_0000;
  localparam logic [31:0] ResumeReq    = 32'h4000_0000;
  localparam logic [31:0] CmdWriteDpc  = 32'h0023_07B1;
  localparam logic [31:0] CmderrClear  = 32'h0000_0700;

  localparam logic [StepW-1:0] StepActivate   = 4'd1;
  localparam logic [StepW-1:0] StepHaltReq    = 4'd2;
  localparam logic [StepW-1:0] StepHaltPoll   = 4'd3;
  localparam logic [StepW-1:0] StepHaltClr    = 4'd4;
  localparam logic [StepW-1:0] StepLoad       = 4'd5;
  localparam logic [StepW-1:0] StepData0      = 4'd6;
  localparam logic [StepW-1:0] StepCommand    = 4'd7;
  localparam logic [StepW-1:0] StepBusyPoll   = 4'd8;
  localparam logic [StepW-1:0] StepResumeReq  = 4'd9;
  localparam logic [StepW-1:0] StepResumePoll = 4'd10;
  localparam logic [StepW-1:0] StepResumeClr  = 4'd11;
  localparam logic [StepW-1:0] StepCmderrClr  = 4'd12;

  localparam logic [2:0] ErrNone     = 3'd0;
  localparam logic [2:0] ErrResp     = 3'd1;
  localparam logic [2:0] ErrCmderr   = 3'd2;
  localparam logic [2:0] ErrHaltTo   = 3'd3;
  localparam logic [2:0] ErrResumeTo = 3'd4;
  localparam logic [2:0] ErrBusyTo   = 3'd5;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RESP,
    WAIT_LOAD,
    DONE,
    ERROR
  } state_e;

  typedef struct packed {
    logic [6:0]  addr;
    logic [1:0]  op;
    logic [31:0] data;
  } dmi_req_t;

  state_e           state_q, state_d;
  logic [StepW-1:0] step_q, step_d;
  logic [PollW-1:0] poll_q, poll_d;
  logic [2:0]       err_q, err_d;
  logic             armed_q;
  dmi_req_t         req_q;
  logic             poll_last;
  logic             unused_resp_bits;

  // DMI transaction issued by each step; reads carry zero data.
  function automatic dmi_req_t step_req(input logic [StepW-1:0] step);
    dmi_req_t r;
    r = '0;
    case (step)
      StepActivate: begin
        r.addr = AddrDmcontrol;  r.op = OpWrite; r.data = 32'h0000_0001;
      end
      StepHaltReq: begin
        r.addr = AddrDmcontrol;  r.op = OpWrite; r.data = DmActiveHart | HaltReq;
      end
      StepHaltPoll, StepResumePoll: begin
        r.addr = AddrDmstatus;   r.op = OpRead;
      end
      StepHaltClr, StepResumeClr: begin
        r.addr = AddrDmcontrol;  r.op = OpWrite; r.data = DmActiveHart;
      end
      StepData0: begin
        r.addr = AddrData0;      r.op = OpWrite; r.data = BootAddr;
      end
      StepCommand: begin
        r.addr = AddrCommand;    r.op = OpWrite; r.data = CmdWriteDpc;
      end
      StepBusyPoll: begin
        r.addr = AddrAbstractcs; r.op = OpRead;
      end
      StepResumeReq: begin
        r.addr = AddrDmcontrol;  r.op = OpWrite; r.data = DmActiveHart | ResumeReq;
      end
      StepCmderrClr: begin
        r.addr = AddrAbstractcs; r.op = OpWrite; r.data = CmderrClear;
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  assign poll_last = (poll_q == PollLast);
  assign unused_resp_bits = ^{dmi_resp_data_i[31:18], dmi_resp_data_i[16:13],
                              dmi_resp_data_i[11], dmi_resp_data_i[7:0]};

  // State and sequencing registers; armed_q masks a start on the first edge out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      step_q  <= '0;
      poll_q  <= '0;
      err_q   <= ErrNone;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      poll_q  <= poll_d;
      err_q   <= err_d;
      armed_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    poll_d  = poll_q;
    err_d   = err_q;
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start_i && armed_q) begin
          state_d = REQ;
          step_d  = StepActivate;
          poll_d  = '0;
          err_d   = ErrNone;
        end
      end
      REQ: begin
        if (dmi_req_valid_o && dmi_req_ready_i) state_d = RESP;
      end
      RESP: begin
        if (dmi_resp_valid_i && dmi_resp_ready_o) begin
          state_d = REQ;
          if (dmi_resp_resp_i != 2'd0) begin
            state_d = ERROR;
            err_d   = ErrResp;
          end else begin
            case (step_q)
              StepHaltPoll: begin
                if (dmi_resp_data_i[9]) begin
                  step_d = StepHaltClr;
                  poll_d = '0;
                end else if (poll_last) begin
                  state_d = ERROR;
                  err_d   = ErrHaltTo;
                end else begin
                  poll_d = poll_q + PollW'(1);
                end
              end
              StepHaltClr: begin
                state_d = WAIT_LOAD;
                step_d  = StepLoad;
              end
              StepBusyPoll: begin
                if (!dmi_resp_data_i[12]) begin
                  step_d = (dmi_resp_data_i[10:8] != 3'd0) ? StepCmderrClr : StepResumeReq;
                  poll_d = '0;
                end else if (poll_last) begin
                  state_d = ERROR;
                  err_d   = ErrBusyTo;
                end else begin
                  poll_d = poll_q + PollW'(1);
                end
              end
              StepResumePoll: begin
                if (dmi_resp_data_i[17]) begin
                  step_d = StepResumeClr;
                  poll_d = '0;
                end else if (poll_last) begin
                  state_d = ERROR;
                  err_d   = ErrResumeTo;
                end else begin
                  poll_d = poll_q + PollW'(1);
                end
              end
              StepResumeClr: state_d = DONE;
              StepCmderrClr: begin
                state_d = ERROR;
                err_d   = ErrCmderr;
              end
              default: begin
                step_d = step_q + StepW'(1);
                poll_d = '0;
              end
            endcase
          end
        end
      end
      WAIT_LOAD: begin
        if (load_done_i) begin
          state_d = REQ;
          step_d  = StepData0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs registered from the next state so they track the state register exactly.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dmi_req_valid_o  <= 1'b0;
      req_q            <= '0;
      dmi_resp_ready_o <= 1'b0;
      busy_o           <= 1'b0;
      load_req_o       <= 1'b0;
      done_o           <= 1'b0;
      error_o          <= 1'b0;
    end else begin
      dmi_req_valid_o  <= (state_d == REQ);
      req_q            <= (state_d == REQ) ? step_req(step_d) : '0;
      dmi_resp_ready_o <= (state_d == RESP);
      busy_o           <= (state_d == REQ) || (state_d == RESP) || (state_d == WAIT_LOAD);
      load_req_o       <= (state_d == WAIT_LOAD);
      done_o           <= (state_d == DONE);
      error_o          <= (state_d == ERROR);
    end
  end

  assign dmi_req_addr_o = req_q.addr;
  assign dmi_req_op_o   = req_q.op;
  assign dmi_req_data_o = req_q.data;
  assign err_code_o     = err_q;

endmodule

// File: tb/tb_dmi_boot_sequencer.sv
// Randomized bench: a DM/loader responder feeds the sequencer while a
// transaction-level model of the boot flow predicts the DMI traffic and outcome.
module tb_dmi_boot_sequencer;

  localparam logic [31:0] BOOT = 32'h8000_0000;
  localparam logic [9:0]  HART = 10'd5;
  localparam int          PT   = 4;
  localparam logic [31:0] H    = {6'd0, HART, 15'd0, 1'b1};
  localparam logic [1:0]  RD   = 2'd1;
  localparam logic [1:0]  WR   = 2'd2;

  typedef struct packed {
    logic [6:0]  addr;
    logic [1:0]  op;
    logic [31:0] data;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic        load_req_o;
  logic        load_done_i = 1'b0;
  logic        dmi_req_valid_o;
  logic        dmi_req_ready_i = 1'b0;
  logic [6:0]  dmi_req_addr_o;
  logic [1:0]  dmi_req_op_o;
  logic [31:0] dmi_req_data_o;
  logic        dmi_resp_valid_i = 1'b0;
  logic        dmi_resp_ready_o;
  logic [31:0] dmi_resp_data_i = '0;
  logic [1:0]  dmi_resp_resp_i = '0;
  logic        busy_o, done_o, error_o;
  logic [2:0]  err_code_o;

  dmi_boot_sequencer #(.BootAddr(BOOT), .HartSel(HART), .PollTimeout(PT)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i),
    .load_req_o(load_req_o), .load_done_i(load_done_i),
    .dmi_req_valid_o(dmi_req_valid_o), .dmi_req_ready_i(dmi_req_ready_i),
    .dmi_req_addr_o(dmi_req_addr_o), .dmi_req_op_o(dmi_req_op_o),
    .dmi_req_data_o(dmi_req_data_o), .dmi_resp_valid_i(dmi_resp_valid_i),
    .dmi_resp_ready_o(dmi_resp_ready_o), .dmi_resp_data_i(dmi_resp_data_i),
    .dmi_resp_resp_i(dmi_resp_resp_i), .busy_o(busy_o), .done_o(done_o),
    .error_o(error_o), .err_code_o(err_code_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scenario knobs and DM-side state.
  int         halt_fail, busy_fail, resume_fail, err_idx, stall_max, delay_max;
  logic [2:0] cmderr_val;
  int         halt_cnt, busy_cnt, resume_cnt, txn_cnt, stall_left, delay_left;
  int         load_cnt, load_phases;
  bit         resume_seen, pending, held_valid, load_seen;
  txn_t       held;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_code;
  txn_t       got_q[$];
  txn_t       exp_q[$];
  int         exp_err, exp_loads, m_idx;
  bit         exp_done;

  function automatic logic [63:0] all_outs();
    return 64'({load_req_o, dmi_req_valid_o, dmi_req_addr_o, dmi_req_op_o, dmi_req_data_o,
                dmi_resp_ready_o, busy_o, done_o, error_o, err_code_o});
  endfunction

  // Behaviour of a DM that halts, finishes commands and resumes after configured read counts.
  task automatic dm_accept(input txn_t t);
    rsp_code = (txn_cnt == err_idx) ? 2'd2 : 2'd0;
    txn_cnt++;
    rsp_data = '0;
    if (t.op == WR && t.addr == 7'h10 && t.data[30]) resume_seen = 1'b1;
    if (t.op == RD && t.addr == 7'h11) begin
      if (!resume_seen) begin
        if (halt_cnt >= halt_fail) rsp_data[9] = 1'b1;
        halt_cnt++;
      end else begin
        if (resume_cnt >= resume_fail) rsp_data[17] = 1'b1;
        resume_cnt++;
      end
    end
    if (t.op == RD && t.addr == 7'h16) begin
      if (busy_cnt < busy_fail) rsp_data[12] = 1'b1;
      else rsp_data[10:8] = cmderr_val;
      busy_cnt++;
    end
    got_q.push_back(t);
  endtask

  initial begin
    stall_left = -1;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        dmi_req_ready_i  = 1'b0;
        dmi_resp_valid_i = 1'b0;
        load_done_i      = 1'b0;
        pending          = 1'b0;
        held_valid       = 1'b0;
        stall_left       = -1;
        load_cnt         = 0;
        load_seen        = 1'b0;
      end else begin
        txn_t cur;
        if (dmi_resp_valid_i) begin
          dmi_resp_valid_i = 1'b0;
          pending = 1'b0;
        end
        cur.addr = dmi_req_addr_o;
        cur.op   = dmi_req_op_o;
        cur.data = dmi_req_data_o;
        if (dmi_req_ready_i) begin
          dmi_req_ready_i = 1'b0;
        end else if (dmi_req_valid_o) begin
          if (held_valid) check_eq("req_stable", 64'(cur), 64'(held));
          if (stall_left < 0) stall_left = int'($urandom_range(stall_max, 0));
          if (stall_left == 0) begin
            dmi_req_ready_i = 1'b1;
            dm_accept(cur);
            pending    = 1'b1;
            delay_left = int'($urandom_range(delay_max, 0));
            held_valid = 1'b0;
            stall_left = -1;
          end else begin
            stall_left--;
            held       = cur;
            held_valid = 1'b1;
          end
        end
        if (pending && !dmi_resp_valid_i && dmi_resp_ready_o) begin
          if (delay_left > 0) delay_left--;
          else begin
            dmi_resp_valid_i = 1'b1;
            dmi_resp_data_i  = rsp_data;
            dmi_resp_resp_i  = rsp_code;
          end
        end
        if (load_req_o) begin
          check_eq("no_req_in_load", 64'(dmi_req_valid_o), 64'd0);
          if (!load_seen) load_phases++;
          load_seen = 1'b1;
          load_cnt++;
          if (load_cnt >= 5) load_done_i = 1'b1;
        end else begin
          load_seen   = 1'b0;
          load_cnt    = 0;
          load_done_i = 1'b0;
        end
      end
    end
  end

  // Reference model: expected DMI traffic and outcome of one boot attempt.
  task automatic exp_push(input logic [6:0] a, input logic [1:0] op, input logic [31:0] d,
                          output bit ab);
    txn_t t;
    t.addr = a; t.op = op; t.data = d;
    exp_q.push_back(t);
    ab = (m_idx == err_idx);
    m_idx++;
  endtask

  task automatic build_expected();
    bit ab, ok;
    exp_q.delete(); m_idx = 0; exp_err = 0; exp_done = 1'b0; exp_loads = 0;
    exp_push(7'h10, WR, 32'h1, ab);             if (ab) begin exp_err = 1; return; end
    exp_push(7'h10, WR, H | 32'h8000_0000, ab); if (ab) begin exp_err = 1; return; end
    ok = 1'b0;
    for (int r = 1; r <= PT; r++) begin
      exp_push(7'h11, RD, 32'h0, ab);           if (ab) begin exp_err = 1; return; end
      if (r > halt_fail) begin ok = 1'b1; break; end
    end
    if (!ok) begin exp_err = 3; return; end
    exp_push(7'h10, WR, H, ab);                 if (ab) begin exp_err = 1; return; end
    exp_loads = 1;
    exp_push(7'h04, WR, BOOT, ab);              if (ab) begin exp_err = 1; return; end
    exp_push(7'h17, WR, 32'h0023_07B1, ab);     if (ab) begin exp_err = 1; return; end
    ok = 1'b0;
    for (int r = 1; r <= PT; r++) begin
      exp_push(7'h16, RD, 32'h0, ab);           if (ab) begin exp_err = 1; return; end
      if (r > busy_fail) begin ok = 1'b1; break; end
    end
    if (!ok) begin exp_err = 5; return; end
    if (cmderr_val != 3'd0) begin
      exp_push(7'h16, WR, 32'h0000_0700, ab);   if (ab) begin exp_err = 1; return; end
      exp_err = 2;
      return;
    end
    exp_push(7'h10, WR, H | 32'h4000_0000, ab); if (ab) begin exp_err = 1; return; end
    ok = 1'b0;
    for (int r = 1; r <= PT; r++) begin
      exp_push(7'h11, RD, 32'h0, ab);           if (ab) begin exp_err = 1; return; end
      if (r > resume_fail) begin ok = 1'b1; break; end
    end
    if (!ok) begin exp_err = 4; return; end
    exp_push(7'h10, WR, H, ab);                 if (ab) begin exp_err = 1; return; end
    exp_done = 1'b1;
  endtask

  task automatic set_cfg(input int hf, input int bf, input int rf, input logic [2:0] cm,
                         input int ei, input int sm, input int dm);
    halt_fail = hf; busy_fail = bf; resume_fail = rf; cmderr_val = cm;
    err_idx = ei; stall_max = sm; delay_max = dm;
  endtask

  task automatic dm_clear();
    halt_cnt = 0; busy_cnt = 0; resume_cnt = 0; txn_cnt = 0;
    resume_seen = 1'b0; got_q.delete(); load_phases = 0;
  endtask

  task automatic run_case(input string name, input bit mid_start);
    int cyc;
    txn_t g;
    dm_clear();
    build_expected();
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    check_eq({name, "_start"}, 64'({busy_o, done_o, error_o, err_code_o}), 64'(6'b100000));
    cyc = 0;
    while (!(done_o || error_o) && cyc < 3000) begin
      start_i = mid_start && (cyc == 20) && busy_o;
      @(negedge clk);
      cyc++;
    end
    start_i = 1'b0;
    check_eq({name, "_ends"}, 64'(cyc < 3000), 64'd1);
    repeat (10) @(negedge clk);
    check_eq({name, "_ntxn"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got_q.size()) ? got_q[i] : '0;
      check_eq($sformatf("%s_txn%0d", name, i), 64'(g), 64'(exp_q[i]));
    end
    check_eq({name, "_status"},
             64'({done_o, error_o, err_code_o, busy_o, dmi_req_valid_o, load_req_o}),
             64'({exp_done, exp_err != 0, 3'(exp_err), 3'b000}));
    check_eq({name, "_loads"}, 64'(load_phases), 64'(exp_loads));
  endtask

  task automatic release_with_start();
    @(negedge clk);
    rst_ni  = 1'b1;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check_eq("start_at_release_ignored", 64'({busy_o, dmi_req_valid_o}), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int cyc;
    set_cfg(0, 0, 0, 3'd0, -1, 0, 0);
    repeat (3) @(negedge clk);
    check_eq("reset_outputs", all_outs(), 64'd0);
    @(negedge clk) rst_ni = 1'b1;
    repeat (2) @(negedge clk);

    run_case("zero_wait", 1'b0);

    for (int k = 0; k < 3; k++) begin
      set_cfg(int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
              int'($urandom_range(3, 0)), 3'd0, -1, 7, 2);
      run_case($sformatf("stall%0d", k), 1'b1);
    end

    set_cfg(1000, 0, 0, 3'd0, -1, 0, 0);   run_case("halt_timeout", 1'b0);
    set_cfg(0, 3, 0, 3'd3, -1, 0, 0);      run_case("cmderr", 1'b0);
    set_cfg(0, 0, 0, 3'd0, 5, 0, 0);       run_case("resp_err_step7", 1'b0);
    set_cfg(0, 0, 0, 3'd0, -1, 0, 0);      run_case("restart", 1'b0);
    set_cfg(3, 3, 3, 3'd0, -1, 2, 1);      run_case("poll_last_ok", 1'b0);
    set_cfg(0, 1000, 0, 3'd0, -1, 0, 0);   run_case("busy_timeout", 1'b0);
    set_cfg(0, 0, 1000, 3'd0, -1, 0, 0);   run_case("resume_timeout", 1'b0);

    for (int k = 0; k < 8; k++) begin
      set_cfg(int'($urandom_range(5, 0)), int'($urandom_range(5, 0)),
              int'($urandom_range(5, 0)),
              ($urandom_range(1, 0) == 0) ? 3'd0 : 3'($urandom_range(7, 1)),
              ($urandom_range(3, 0) == 0) ? int'($urandom_range(12, 0)) : -1,
              int'($urandom_range(3, 0)), int'($urandom_range(2, 0)));
      run_case($sformatf("rand%0d", k), 1'b0);
    end

    // Reset while the loader owns the hart.
    set_cfg(0, 0, 0, 3'd0, -1, 0, 0);
    dm_clear();
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    cyc = 0;
    while (!load_req_o && cyc < 500) begin @(negedge clk); cyc++; end
    check_eq("reach_wait_load", 64'(load_req_o), 64'd1);
    #2 rst_ni = 1'b0;
    #1 check_eq("reset_in_wait_load", all_outs(), 64'd0);
    repeat (2) @(negedge clk);
    release_with_start();
    run_case("after_reset_load", 1'b0);

    // Reset while a response is outstanding.
    dm_clear();
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    cyc = 0;
    while (!dmi_resp_ready_o && cyc < 500) begin @(negedge clk); cyc++; end
    check_eq("reach_resp", 64'(dmi_resp_ready_o), 64'd1);
    #1 rst_ni = 1'b0;
    #1 check_eq("reset_in_resp", all_outs(), 64'd0);
    repeat (2) @(negedge clk);
    release_with_start();
    run_case("after_reset_resp", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
